modadd_ctrl: RTL and testbench



---
 rtl/ecc_pkg.sv | 21 ++
 rtl/adder.sv | 47 ++++
 rtl/modadd_ctrl.sv | 136 +++++++++++++
 tb/tb_modadd_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared ECC datapath constants, modular-add sequencer states and adder modes
package ecc_pkg;

    // Operand width of the ECC field arithmetic.
    localparam int OPW = 384;

    // Modular add/sub sequencer states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P1_GO   = 3'd1,
        P1_WAIT = 3'd2,
        P2_GO   = 3'd3,
        P2_WAIT = 3'd4,
        FIN     = 3'd5
    } modadd_state_t;

    // Adder mode select values.
    localparam logic ADD_MODE = 1'b0;
    localparam logic SUB_MODE = 1'b1;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - N-bit add/sub datapath with fixed completion latency
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start              one-cycle request; operands sampled with it
//   subtract           0: a+b, 1: a-b
//   in_a, in_b         N-bit operands
//   result             N+1-bit result; bit N is carry (add) or borrow (sub)
//   done               completion pulse LAT cycles after start
module adder #(
    parameter int N   = 384,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         subtract,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic [N:0]   result,
    output logic         done
);

    // Countdown to completion; done is raised while it holds 1.
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= 8'd0;
            result <= '0;
        end else begin
            if (start) begin
                cnt <= 8'(LAT);
                // Zero-extending both operands makes bit N the carry/borrow.
                if (subtract)
                    result <= {1'b0, in_a} - {1'b0, in_b};
                else
                    result <= {1'b0, in_a} + {1'b0, in_b};
            end else if (cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
        end
    end

    assign done = (cnt == 8'd1);

endmodule

// File: rtl/modadd_ctrl.sv
// rtl/modadd_ctrl.sv - two-pass (A +/- B) mod M sequencer driving an external add/sub datapath
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   start, subtract                request pulse and mode (0: add, 1: subtract)
//   in_a, in_b, in_m               operands and modulus, sampled with start
//   busy, done, result             status, completion pulse, held modular result
//   add_start, add_subtract        adder request pulse and mode
//   add_in_a, add_in_b             adder operands, held through the pass
//   add_result, add_done           adder N+1-bit result and completion pulse
//
// Build option MODADD_EARLY_EXIT_EN: a subtraction without borrow finishes
// after the first pass instead of running the correction pass.
module modadd_ctrl
    import ecc_pkg::*;
#(
    parameter int N = OPW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         subtract,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         add_start,
    output logic         add_subtract,
    output logic [N-1:0] add_in_a,
    output logic [N-1:0] add_in_b,
    input  logic [N:0]   add_result,
    input  logic         add_done
);

    modadd_state_t state;
    logic          sub;
    logic [N-1:0]  m_q;
    logic [N:0]    r1;

    // Pick the corrected or uncorrected value from the two passes.
    // Add:  r1 = a+b, r2 = r1-m. Use r2 unless r1 < m (no carry and r2 borrowed).
    // Sub:  r1 = a-b, r2 = r1+m. Use r2 only when r1 borrowed.
    function automatic logic [N-1:0] select_result(input logic is_sub,
                                                  input logic [N:0] p1,
                                                  input logic [N:0] p2);
        if (is_sub)
            select_result = p1[N] ? p2[N-1:0] : p1[N-1:0];
        else
            select_result = (p1[N] || !p2[N]) ? p2[N-1:0] : p1[N-1:0];
    endfunction

    // Adder request registers are loaded on entry to P*_GO so that the
    // start pulse coincides with the GO state and operands stay stable
    // until the matching add_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sub          <= 1'b0;
            m_q          <= '0;
            r1           <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            add_start    <= 1'b0;
            add_subtract <= 1'b0;
            add_in_a     <= '0;
            add_in_b     <= '0;
        end else begin
            add_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sub          <= subtract;
                        m_q          <= in_m;
                        busy         <= 1'b1;
                        add_start    <= 1'b1;
                        add_subtract <= subtract ? SUB_MODE : ADD_MODE;
                        add_in_a     <= in_a;
                        add_in_b     <= in_b;
                        state        <= P1_GO;
                    end
                end
                P1_GO: begin
                    state <= P1_WAIT;
                end
                P1_WAIT: begin
                    if (add_done) begin
                        r1 <= add_result;
`ifdef MODADD_EARLY_EXIT_EN
                        if (sub && !add_result[N]) begin
                            // No borrow: the raw difference is already reduced.
                            result <= add_result[N-1:0];
                            done   <= 1'b1;
                            state  <= FIN;
                        end else begin
                            add_start    <= 1'b1;
                            add_subtract <= sub ? ADD_MODE : SUB_MODE;
                            add_in_a     <= add_result[N-1:0];
                            add_in_b     <= m_q;
                            state        <= P2_GO;
                        end
`else
                        add_start    <= 1'b1;
                        add_subtract <= sub ? ADD_MODE : SUB_MODE;
                        add_in_a     <= add_result[N-1:0];
                        add_in_b     <= m_q;
                        state        <= P2_GO;
`endif
                    end
                end
                P2_GO: begin
                    state <= P2_WAIT;
                end
                P2_WAIT: begin
                    if (add_done) begin
                        result <= select_result(sub, r1, add_result);
                        done   <= 1'b1;
                        state  <= FIN;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modadd_ctrl.sv
// tb/tb_modadd_ctrl.sv - directed self-checking bench for modadd_ctrl with the adder datapath
module tb_modadd_ctrl;
    import ecc_pkg::*;

    localparam int N = OPW;

    logic         clk;
    logic         reset;
    logic         start;
    logic         subtract;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [N-1:0] in_m;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         add_start;
    logic         add_subtract;
    logic [N-1:0] add_in_a;
    logic [N-1:0] add_in_b;
    logic [N:0]   add_result;
    logic         add_done;

    int errors = 0;
    int checks = 0;

`ifdef MODADD_EARLY_EXIT_EN
    localparam int LAT_SUB_NB = 3;
`else
    localparam int LAT_SUB_NB = 5;
`endif
    localparam int LAT_FULL = 5;

    modadd_ctrl #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .subtract(subtract),
        .in_a(in_a), .in_b(in_b), .in_m(in_m),
        .busy(busy), .done(done), .result(result),
        .add_start(add_start), .add_subtract(add_subtract),
        .add_in_a(add_in_a), .add_in_b(add_in_b),
        .add_result(add_result), .add_done(add_done)
    );

    adder #(.N(N), .LAT(1)) u_adder (
        .clk(clk), .reset(reset), .start(add_start), .subtract(add_subtract),
        .in_a(add_in_a), .in_b(add_in_b), .result(add_result), .done(add_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation from a point 1 time unit after a rising edge.
    // lat counts cycles from the start-sampling cycle (cycle 0) to done.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] m, input logic s,
                          output logic [N-1:0] res, output int lat,
                          output int busy_bad);
        start = 1'b1; subtract = s; in_a = a; in_b = b; in_m = m;
        @(posedge clk); #1;
        start = 1'b0;
        // Later input changes must not disturb the accepted operation.
        subtract = ~s; in_a = '1; in_b = '1; in_m = 384'd3;
        lat = 1;
        busy_bad = 0;
        while (done !== 1'b1 && lat < 50) begin
            if (busy !== 1'b1) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic check_op(input string name, input logic [N-1:0] a,
                            input logic [N-1:0] b, input logic [N-1:0] m,
                            input logic s, input logic [N-1:0] exp_res,
                            input int exp_lat);
        logic [N-1:0] res;
        int lat, bb;
        run_op(a, b, m, s, res, lat, bb);
        checks++;
        if (res !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, res, exp_res);
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (bb != 0) begin
            errors++;
            $display("FAIL %s busy: low in %0d cycles before done, expected 0", name, bb);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; subtract = 1'b0;
        in_a = '0; in_b = '0; in_m = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
        checks++; if (add_start !== 1'b0) begin errors++; $display("FAIL reset_add_start: got %b expected 0", add_start); end
        checks++; if (add_subtract !== 1'b0) begin errors++; $display("FAIL reset_add_subtract: got %b expected 0", add_subtract); end
        checks++; if (add_in_a !== '0 || add_in_b !== '0) begin errors++; $display("FAIL reset_add_in: got %h/%h expected 0/0", add_in_a, add_in_b); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        logic [N-1:0] mx;
        mx = '1;
        check_op("add_wrap", 384'd5, 384'd7, 384'd11, 1'b0, 384'd1, LAT_FULL);
        check_op("add_nowrap", 384'd2, 384'd3, 384'd11, 1'b0, 384'd5, LAT_FULL);
        check_op("add_max", mx - 384'd1, mx - 384'd1, mx, 1'b0, mx - 384'd2, LAT_FULL);
    endtask

    task automatic test_sub();
        check_op("sub_borrow", 384'd3, 384'd8, 384'd11, 1'b1, 384'd6, LAT_FULL);
        check_op("sub_noborrow", 384'd9, 384'd4, 384'd11, 1'b1, 384'd5, LAT_SUB_NB);
    endtask

    task automatic test_zero();
        check_op("zero_add", 384'd0, 384'd0, 384'd11, 1'b0, 384'd0, LAT_FULL);
        check_op("zero_sub", 384'd0, 384'd0, 384'd11, 1'b1, 384'd0, LAT_SUB_NB);
        check_op("equal_sub", 384'd10, 384'd10, 384'd11, 1'b1, 384'd0, LAT_SUB_NB);
    endtask

    task automatic test_start_while_busy();
        int pulses = 0;
        logic [N-1:0] first_res = '0;
        start = 1'b1; subtract = 1'b0; in_a = 384'd5; in_b = 384'd7; in_m = 384'd11;
        @(posedge clk); #1;                 // cycle 1
        start = 1'b0;
        @(posedge clk); #1;                 // cycle 2: competing request
        start = 1'b1; subtract = 1'b1; in_a = 384'd3; in_b = 384'd8; in_m = 384'd11;
        @(posedge clk); #1;                 // cycle 3
        start = 1'b0;
        for (int c = 3; c < 16; c++) begin
            if (done === 1'b1) begin
                pulses++;
                first_res = result;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL busy_start_pulses: got %0d expected 1", pulses); end
        checks++;
        if (first_res !== 384'd1) begin errors++; $display("FAIL busy_start_result: got %h expected 1", first_res); end
        checks++;
        if (result !== 384'd1) begin errors++; $display("FAIL result_held: got %h expected 1", result); end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] res;
        int lat, bb;
        start = 1'b1; subtract = 1'b0; in_a = 384'd5; in_b = 384'd7; in_m = 384'd11;
        @(posedge clk); #1;                 // cycle 1
        start = 1'b0;
        @(posedge clk); #1;                 // cycle 2
        @(posedge clk); #1;                 // cycle 3
        reset = 1'b1;
        @(posedge clk); #1;                 // cycle 4
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (result !== '0) begin errors++; $display("FAIL midreset_result: got %h expected 0", result); end
        checks++; if (add_start !== 1'b0) begin errors++; $display("FAIL midreset_add_start: got %b expected 0", add_start); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", done); end
        run_op(384'd1, 384'd1, 384'd11, 1'b0, res, lat, bb);
        checks++;
        if (res !== 384'd2) begin errors++; $display("FAIL after_reset_result: got %h expected 2", res); end
        checks++;
        if (lat != LAT_FULL) begin errors++; $display("FAIL after_reset_latency: got %0d expected %0d", lat, LAT_FULL); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_zero();
        test_start_while_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
